// File: rtl/dsp_arb_pkg.sv
// dsp_arb_pkg: shared constants and helpers for the DSP share arbiter.
// Requester IDs, default widths and the round-robin step function.
package dsp_arb_pkg;

  localparam int ID_TWIDDLE = 0;
  localparam int ID_WINDOW  = 1;
  localparam int ID_GAIN    = 2;

  localparam int NREQ_DEF    = 3;
  localparam int ID_W_DEF    = 2;
  localparam int A_W_DEF     = 25;
  localparam int B_W_DEF     = 11;
  localparam int C_W_DEF     = 35;
  localparam int P_W_DEF     = 35;
  localparam int DSP_LAT_DEF = 0;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dsp_share_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, search starts just after ptr.
// With fixed set the search always starts at index 0.
module rr_pick
  import dsp_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  input  logic            fixed,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] id,
  output logic            found
);

  int idx;

  // Walk all NREQ slots once; the first valid slot wins.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = fixed ? 0 : rr_next(int'(ptr), NREQ);
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
      idx = rr_next(idx, NREQ);
    end
  end

endmodule

// File: rtl/dsp_share_arbiter.sv
// dsp_share_arbiter: time-shares one external mult_add between NREQ users.
// Build macro DSP_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module dsp_share_arbiter
  import dsp_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int A_WIDTH = A_W_DEF,
  parameter int B_WIDTH = B_W_DEF,
  parameter int C_WIDTH = C_W_DEF,
  parameter int P_WIDTH = P_W_DEF,
  parameter int DSP_LAT = DSP_LAT_DEF
) (
  input  logic                    clk_3x_i,
  input  logic                    rst_n,
  input  logic                    hold_i,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*A_WIDTH-1:0] req_a_i,
  input  logic [NREQ*B_WIDTH-1:0] req_b_i,
  input  logic [NREQ*C_WIDTH-1:0] req_c_i,
  output logic [A_WIDTH-1:0]      dsp_a_o,
  output logic [B_WIDTH-1:0]      dsp_b_o,
  output logic [C_WIDTH-1:0]      dsp_c_o,
  input  logic [P_WIDTH-1:0]      dsp_p_i,
  output logic                    res_valid_o,
  output logic [ID_W-1:0]         res_id_o,
  output logic [P_WIDTH-1:0]      res_p_o,
  output logic                    busy_o
);

  localparam int DEPTH = DSP_LAT + 1;

  if (P_WIDTH < A_WIDTH + B_WIDTH - 1) begin : g_bad_p
    $error("P_WIDTH narrower than A_WIDTH+B_WIDTH-1");
  end
  if (ID_W < $clog2(NREQ)) begin : g_bad_id
    $error("ID_W too small for NREQ");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_n
    $error("NREQ must be 2..8");
  end
  if (DSP_LAT < 0 || DSP_LAT > 4) begin : g_bad_lat
    $error("DSP_LAT must be 0..4");
  end

`ifdef DSP_ARB_FIXED_PRIO_EN
  localparam logic FIXED = 1'b1;
`else
  localparam logic FIXED = 1'b0;
`endif

  logic [ID_W-1:0]  ptr;
  logic [NREQ-1:0]  cand;
  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  gid;
  logic             found;
  logic             accept;
  logic [DEPTH-1:0] tv;
  logic [ID_W-1:0]  tid [DEPTH];

  assign cand = hold_i ? '0 : req_valid_i;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .valid (cand),
    .ptr   (ptr),
    .fixed (FIXED),
    .grant (grant),
    .id    (gid),
    .found (found)
  );

  assign req_ready_o = rst_n ? grant : '0;
  assign accept      = rst_n & found;
  assign busy_o      = |tv;

  // Operand registers only move on an accept, so the DSP inputs stay quiet.
  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      dsp_a_o <= '0;
      dsp_b_o <= '0;
      dsp_c_o <= '0;
      ptr     <= ID_W'(NREQ - 1);
    end else if (accept) begin
      dsp_a_o <= req_a_i[int'(gid)*A_WIDTH +: A_WIDTH];
      dsp_b_o <= req_b_i[int'(gid)*B_WIDTH +: B_WIDTH];
      dsp_c_o <= req_c_i[int'(gid)*C_WIDTH +: C_WIDTH];
      ptr     <= gid;
    end
  end

  // Issue tags shadow the operand register plus the DSP's internal stages.
  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      tv <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tid[k] <= '0;
      end
    end else begin
      tv[0]  <= accept;
      tid[0] <= gid;
      for (int k = 1; k < DEPTH; k++) begin
        tv[k]  <= tv[k-1];
        tid[k] <= tid[k-1];
      end
    end
  end

  // Capture the DSP output when the matching tag reaches the end.
  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      res_valid_o <= 1'b0;
      res_id_o    <= '0;
      res_p_o     <= '0;
    end else begin
      res_valid_o <= tv[DEPTH-1];
      if (tv[DEPTH-1]) begin
        res_id_o <= tid[DEPTH-1];
        res_p_o  <= dsp_p_i;
      end
    end
  end

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// tb_dsp_share_arbiter: directed checks of grant order, latency and reset.
// Expected tables switch with DSP_ARB_FIXED_PRIO_EN.
module tb_dsp_share_arbiter;
  import dsp_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int ID_W = 2;
  localparam int A_W  = 25;
  localparam int B_W  = 11;
  localparam int C_W  = 35;
  localparam int P_W  = 35;
  localparam int LAT  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                hold = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a = '0;
  logic [NREQ*B_W-1:0] req_b = '0;
  logic [NREQ*C_W-1:0] req_c = '0;
  logic [A_W-1:0]      dsp_a;
  logic [B_W-1:0]      dsp_b;
  logic [C_W-1:0]      dsp_c;
  logic [P_W-1:0]      dsp_p;
  logic                res_valid;
  logic [ID_W-1:0]     res_id;
  logic [P_W-1:0]      res_p;
  logic                busy;

  dsp_share_arbiter #(
    .NREQ(NREQ), .ID_W(ID_W), .A_WIDTH(A_W), .B_WIDTH(B_W),
    .C_WIDTH(C_W), .P_WIDTH(P_W), .DSP_LAT(LAT)
  ) dut (
    .clk_3x_i    (clk),
    .rst_n       (rst_n),
    .hold_i      (hold),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_c_i     (req_c),
    .dsp_a_o     (dsp_a),
    .dsp_b_o     (dsp_b),
    .dsp_c_o     (dsp_c),
    .dsp_p_i     (dsp_p),
    .res_valid_o (res_valid),
    .res_id_o    (res_id),
    .res_p_o     (res_p),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External mult_add model: p = a*b + c with LAT register stages.
  logic [P_W-1:0] prod;
  logic [P_W-1:0] pipe [LAT];
  assign prod = P_W'($signed(dsp_a)) * P_W'($signed(dsp_b)) + dsp_c;
  always @(posedge clk) begin
    pipe[0] <= prod;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign dsp_p = pipe[LAT-1];

  typedef struct { int id; int cyc; } acc_t;
  typedef struct { int id; logic [P_W-1:0] p; int cyc; } res_t;
  acc_t acc_q[$];
  res_t res_q[$];

  always @(negedge clk) begin : mon
    acc_t ae;
    res_t re;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        ae.id  = i;
        ae.cyc = cyc;
        acc_q.push_back(ae);
      end
    end
    if (res_valid === 1'b1) begin
      re.id  = int'(res_id);
      re.p   = res_p;
      re.cyc = cyc;
      res_q.push_back(re);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [P_W-1:0] pe(input int v);
    return P_W'(v);
  endfunction

  task automatic set_op(input int i, input int a, input int b, input int c);
    req_a[i*A_W +: A_W] = A_W'(a);
    req_b[i*B_W +: B_W] = B_W'(b);
    req_c[i*C_W +: C_W] = C_W'(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string tag, input int n,
                           input int eid[6], input int ep[6],
                           input int egap[6]);
    chk({tag, ".nacc"}, acc_q.size(), n);
    chk({tag, ".nres"}, res_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < acc_q.size()) begin
        chk($sformatf("%s.gid%0d", tag, i), acc_q[i].id, eid[i]);
        chk($sformatf("%s.gap%0d", tag, i),
            acc_q[i].cyc - acc_q[0].cyc, egap[i]);
        if (i < res_q.size()) begin
          chk($sformatf("%s.rid%0d", tag, i), res_q[i].id, eid[i]);
          chk($sformatf("%s.p%0d", tag, i), res_q[i].p, pe(ep[i]));
          chk($sformatf("%s.lat%0d", tag, i),
              res_q[i].cyc - acc_q[i].cyc, LAT + 2);
        end
      end
    end
    acc_q.delete();
    res_q.delete();
  endtask

  localparam int T0 = ID_TWIDDLE;
  localparam int T1 = ID_WINDOW;
  localparam int T2 = ID_GAIN;

`ifdef DSP_ARB_FIXED_PRIO_EN
  localparam int B_ID[6] = '{T0, T0, T0, T0, T0, T0};
  localparam int B_P[6]  = '{2, 2, 2, 2, 2, 2};
  localparam int D_ID[6] = '{T0, T0, T0, T0, T0, T0};
  localparam int D_P[6]  = '{2, 2, 2, 2, 2, 2};
  localparam int E_ID[6] = '{T0, T0, T0, T0, T0, T0};
  localparam int E_P[6]  = '{2, 2, 2, 2, 2, 2};
`else
  localparam int B_ID[6] = '{T0, T1, T2, T0, T1, T2};
  localparam int B_P[6]  = '{2, 4, 6, 2, 4, 6};
  localparam int D_ID[6] = '{T2, T0, T1, T2, T0, T0};
  localparam int D_P[6]  = '{6, 2, 4, 6, 2, 0};
  localparam int E_ID[6] = '{T2, T0, T2, T0, T0, T0};
  localparam int E_P[6]  = '{6, 2, 6, 2, 0, 0};
`endif
  localparam int SEQ[6]   = '{0, 1, 2, 3, 4, 5};
  localparam int D_GAP[6] = '{0, 1, 4, 5, 6, 0};
  localparam int C1_ID[6] = '{T0, 0, 0, 0, 0, 0};
  localparam int C1_P[6]  = '{85, 0, 0, 0, 0, 0};
  localparam int C2_ID[6] = '{T1, 0, 0, 0, 0, 0};
  localparam int C2_P[6]  = '{-64, 0, 0, 0, 0, 0};

  initial begin
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 2, 0);
    repeat (3) step();
    chk("rst.ready", req_ready, 0);
    chk("rst.rvalid", res_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.dsp_a", dsp_a, 0);
    chk("rst.res_p", res_p, 0);
    chk("rst.res_id", res_id, 0);
    acc_q.delete();
    res_q.delete();

    // All valid: rotation and back-to-back results.
    rst_n = 1'b1;
    #1;
    chk("rr.first", req_ready, 3'b001);
    repeat (2) step();
    chk("rr.busy", busy, 1);
    repeat (4) step();
    req_valid = '0;
    repeat (8) step();
    chk("rr.idle", busy, 0);
    check_run("rr", 6, B_ID, B_P, SEQ);

    // Single ops with signed operands.
    set_op(0, 3, -5, 100);
    set_op(1, -7, 9, -1);
    req_valid = 3'b001;
    #1;
    chk("c1.ready", req_ready, 3'b001);
    step();
    req_valid = '0;
    repeat (6) step();
    check_run("c1", 1, C1_ID, C1_P, SEQ);
    req_valid = 3'b010;
    #1;
    chk("c2.ready", req_ready, 3'b010);
    step();
    req_valid = '0;
    repeat (6) step();
    check_run("c2", 1, C2_ID, C2_P, SEQ);
    chk("c2.rvalid", res_valid, 0);
    chk("c2.p_hold", res_p, pe(-64));
    chk("c2.id_hold", res_id, 1);

    // Hold for two cycles mid-stream.
    for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 2, 0);
    req_valid = '1;
    step();
    step();
    hold = 1'b1;
    #1;
    chk("hold.ready0", req_ready, 0);
    step();
    chk("hold.ready1", req_ready, 0);
    step();
    hold = 1'b0;
    repeat (3) step();
    req_valid = '0;
    repeat (8) step();
    check_run("hold", 5, D_ID, D_P, D_GAP);

    // Requesters 0 and 2 continuously valid.
    req_valid = 3'b101;
    repeat (4) step();
    req_valid = '0;
    repeat (8) step();
    check_run("pair", 4, E_ID, E_P, SEQ);

    // Reset with two ops in flight.
    req_valid = 3'b011;
    step();
    step();
    chk("f.busy_pre", busy, 1);
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    chk("f.rst_ready", req_ready, 0);
    step();
    chk("f.busy", busy, 0);
    chk("f.rvalid", res_valid, 0);
    chk("f.res_p", res_p, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("f.first", req_ready, 3'b001);
    req_valid = '0;
    repeat (8) step();
    chk("f.nres", res_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
